// File: rtl/text_link_pkg.sv
// text_link_pkg: shared state encoding and defaults for the text link sequencer
package text_link_pkg;
    localparam int KEY_W_DEFAULT   = 8;
    localparam int LEN_W_DEFAULT   = 8;
    localparam int DEFAULT_KEY     = 123;
    localparam int KEY_LOAD_CYCLES = 2;
    typedef enum logic [2:0] {IDLE, KEY_LOAD, KEY_WAIT, STREAM, DRAIN, DONE, ERROR} state_t;
endpackage

// File: rtl/text_token_delay.sv
// text_token_delay: fixed-latency token shift line mirroring the link chain latency
module text_token_delay #(
    parameter int DEPTH = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic din,
    output logic dout,
    output logic empty
);
    logic [DEPTH-1:0] sr;
    // shift one stage per cycle; flush discards every token in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sr <= '0;
        else sr <= flush ? '0 : DEPTH'({sr, din});
    end
    assign dout  = sr[DEPTH-1];
    assign empty = ~|sr;
endmodule

// File: rtl/text_link_ctrl.sv
// text_link_ctrl: key load, cipher init handshake and character metering for the text link
module text_link_ctrl
    import text_link_pkg::*;
#(
    parameter int KEY_W        = KEY_W_DEFAULT,
    parameter int LEN_W        = LEN_W_DEFAULT,
    parameter int PIPE_LAT     = 6,
    parameter int INIT_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [KEY_W-1:0] key_in,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             enc_init_done,
    input  logic             dec_init_done,
    input  logic             sink_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             cipher_rst_n,
    output logic             src_req,
    output logic             sink_valid,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic [LEN_W-1:0] char_count
);
    localparam int FL_W = $clog2(PIPE_LAT + 1);
    localparam int TO_W = $clog2(INIT_TIMEOUT + 1);
    localparam int LD_W = $clog2(KEY_LOAD_CYCLES + 1);

    state_t           state;
    logic [LEN_W-1:0] len_q, issued;
    logic [FL_W-1:0]  in_flight;
    logic [TO_W-1:0]  tmo;
    logic [LD_W-1:0]  ld_cnt;
    logic             init_ok, streaming, accept, flush, line_empty;

    assign init_ok   = enc_init_done && dec_init_done;
    assign streaming = state == STREAM || state == DRAIN;
    assign accept    = start && !abort && (state == IDLE || state == ERROR);
    assign flush     = abort || (streaming && !init_ok);
    assign src_req   = state == STREAM && !abort && init_ok && sink_ready &&
                       issued < len_q && in_flight < FL_W'(PIPE_LAT);

    text_token_delay #(.DEPTH(PIPE_LAT)) u_delay (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .din   (src_req),
        .dout  (sink_valid),
        .empty (line_empty)
    );

    // sequencer: state plus registered key, cipher reset, busy, done and fault flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            key_out      <= '0;
            len_q        <= '0;
            cipher_rst_n <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            tmo          <= '0;
            ld_cnt       <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state        <= IDLE;
                cipher_rst_n <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    IDLE, ERROR: if (start) begin
                        state       <= KEY_LOAD;
                        key_out     <= key_in;
                        len_q       <= msg_len;
                        ld_cnt      <= '0;
                        busy        <= 1'b1;
                        err_timeout <= 1'b0;
                    end
                    KEY_LOAD: if (ld_cnt == LD_W'(KEY_LOAD_CYCLES - 1)) begin
                        state        <= KEY_WAIT;
                        cipher_rst_n <= 1'b1;
                        tmo          <= '0;
                    end else begin
                        ld_cnt <= ld_cnt + LD_W'(1);
                    end
                    KEY_WAIT: if (init_ok && len_q == '0) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        cipher_rst_n <= 1'b0;
                        done         <= 1'b1;
                    end else if (init_ok) begin
                        state <= STREAM;
                    end else if (tmo == TO_W'(INIT_TIMEOUT - 1)) begin
                        state        <= ERROR;
                        busy         <= 1'b0;
                        cipher_rst_n <= 1'b0;
                        err_timeout  <= 1'b1;
                    end else begin
                        tmo <= tmo + TO_W'(1);
                    end
                    STREAM: if (!init_ok) begin
                        state        <= ERROR;
                        busy         <= 1'b0;
                        cipher_rst_n <= 1'b0;
                        err_timeout  <= 1'b1;
                    end else if (issued == len_q) begin
                        state <= DRAIN;
                    end
                    DRAIN: if (!init_ok) begin
                        state        <= ERROR;
                        busy         <= 1'b0;
                        cipher_rst_n <= 1'b0;
                        err_timeout  <= 1'b1;
                    end else if (in_flight == '0 && line_empty) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        cipher_rst_n <= 1'b0;
                        done         <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // issue, in-flight and delivery counters; a new message clears them, a flush empties the pipe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued     <= '0;
            in_flight  <= '0;
            char_count <= '0;
        end else if (accept) begin
            issued     <= '0;
            in_flight  <= '0;
            char_count <= '0;
        end else begin
            issued     <= issued + LEN_W'(src_req);
            in_flight  <= flush ? '0 : in_flight + FL_W'(src_req) - FL_W'(sink_valid);
            char_count <= char_count + LEN_W'(sink_valid);
        end
    end
endmodule
